ntt_seq_ctrl: RTL and testbench
===============================

NTT_SEQ_CTRL -- requirements
Module: ntt_seq_ctrl

Interface
REQ-001 SHALL have parameter N, default 16: transform length (coefficient count); fixed at 16 for this release.
REQ-002 SHALL have parameter DW, default 8: coefficient, modulus and result width.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1: transform request strobe, sampled only in IDLE.
REQ-006 SHALL have port q  input  DW: modulus, latched on accepted start.
REQ-007 SHALL have port w  input  4: root of unity, latched on accepted start.
REQ-008 SHALL have ports in_valid input 1, in_ready output 1, in_data input DW: coefficient stream a[0]..a[15].
REQ-009 SHALL have ports out_valid output 1, out_ready input 1, out_data output DW, out_last output 1: result stream X[0]..X[15].
REQ-010 SHALL have port busy  output  1: high in any state other than IDLE.
REQ-011 SHALL have port done  output  1: one-cycle pulse on the final output handshake.

Function
REQ-012 SHALL implement FSM IDLE -> LOAD -> COMPUTE -> OUTPUT -> IDLE.
REQ-013 IDLE: start=1 latches q, w; next state LOAD; start outside IDLE ignored, no effect.
REQ-014 LOAD: in_ready=1; each in_valid&in_ready stores in_data at index 0..15; after the 16th beat, LOAD -> COMPUTE.
REQ-015 COMPUTE: one MAC per cycle, exactly 256 cycles, outer i=0..15, inner j=0..15; in_ready=0, out_valid=0.
REQ-016 Twiddle: step register = w^i mod q (1 at i=0); at j=0 acc=a[0] mod q and tw=step; for j>=1 acc=(acc+a[j]*tw) mod q, then tw=(tw*step) mod q.
REQ-017 At j=15 result X[i]=acc written to output buffer; step=(step*w) mod q.
REQ-018 Arithmetic: products carried at 2*DW bits, sum at 2*DW+1 bits, reduced mod q every cycle; no truncation before reduction.
REQ-019 q=0 or q=1: all X[i]=0.
REQ-020 OUTPUT: out_valid=1, out_data=X[k], k=0..15; k advances only on out_valid&out_ready; out_data/out_valid stable while stalled.
REQ-021 out_last=1 with X[15]; its handshake pulses done and returns to IDLE.
REQ-022 First out_valid in the cycle after the 256th COMPUTE cycle.
REQ-023 start in the done cycle is ignored; a new start is accepted from the next cycle.

Reset
REQ-024 rst_n=0 asynchronously forces IDLE; in_ready, out_valid, out_last, busy, done = 0; out_data, indices, acc, step, tw = 0.
REQ-025 Reset mid-transform discards all loaded coefficients and partial results; no done pulse.

Configuration
REQ-026 Macro NTT_PERF_CNT_EN defined: port perf_cnt output 16 counts clk cycles spent outside IDLE, cleared on accepted start, saturating at 0xFFFF, held after done; reset value 0.
REQ-027 NTT_PERF_CNT_EN undefined: port perf_cnt and counter absent; all other behaviour identical.

Verification
REQ-028 q=17, w=2, a=[1,0,...,0], out_ready=1 -> X[0..15] all 1, out_last on X[15], one done pulse.
REQ-029 q=17, w=2, a[1]=1 others 0 -> X = 1,2,4,8,16,15,13,9,1,2,4,8,16,15,13,9.
REQ-030 q=17, w=1, all a=1 -> every X=16; NTT_PERF_CNT_EN with no stalls -> perf_cnt=288.
REQ-031 out_ready toggled 1-of-3 cycles, q=251, random a, w=3 -> results match modular DFT model, out_data held during stalls, start during busy ignored.
REQ-032 rst_n pulsed low at COMPUTE cycle 100 -> outputs at reset values immediately, busy=0; subsequent transform correct.
REQ-033 q=1 and q=0, random a -> all 16 X=0, done asserted.

Source files
------------

// File: rtl/ntt_seq_ctrl.sv
// ntt_seq_ctrl: sequential 16-point number-theoretic transform with one modular MAC per cycle.
// Define NTT_PERF_CNT_EN to add the perf_cnt port, which counts busy cycles.
module ntt_seq_ctrl #(
  parameter int N  = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] q,
  input  logic [3:0]    w,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
`ifdef NTT_PERF_CNT_EN
  ,
  output logic [15:0]   perf_cnt
`endif
);

  localparam int IW = $clog2(N);
  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUTPUT} state_t;

  state_t        state;
  logic [DW-1:0] q_reg;
  logic [3:0]    w_reg;
  logic [IW-1:0] ld_idx;
  logic [IW-1:0] i_idx;
  logic [IW-1:0] j_idx;
  logic [IW-1:0] k_idx;
  logic [IW-1:0] k_nxt;
  logic [DW-1:0] acc;
  logic [DW-1:0] step;
  logic [DW-1:0] tw;
  logic [DW-1:0] a_mem [N];
  logic [DW-1:0] x_mem [N];

  logic [DW-1:0] q_div;
  logic [DW-1:0] a_cur;
  logic [PW-1:0] prod;
  logic [SW-1:0] sum;
  logic [DW-1:0] acc_next;
  logic [DW-1:0] tw_next;
  logic [DW-1:0] step_next;
  logic          in_fire;
  logic          out_fire;
  logic          accept;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign accept   = (state == IDLE) & start & ~done;
  assign k_nxt    = k_idx + 1'b1;

  // A modulus of 0 reduces by 1 instead, which yields the all-zero result q=1 produces naturally.
  always_comb begin
    q_div     = (q_reg == '0) ? DW'(1) : q_reg;
    a_cur     = a_mem[j_idx];
    prod      = PW'(a_cur) * PW'(tw);
    sum       = SW'(acc) + SW'(prod);
    acc_next  = '0;
    tw_next   = '0;
    if (j_idx == '0) begin
      acc_next = DW'(a_cur % q_div);
      tw_next  = step;
    end else begin
      acc_next = DW'(sum % SW'(q_div));
      tw_next  = DW'((PW'(tw) * PW'(step)) % PW'(q_div));
    end
    step_next = DW'((PW'(step) * PW'(w_reg)) % PW'(q_div));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q_reg     <= '0;
      w_reg     <= '0;
      ld_idx    <= '0;
      i_idx     <= '0;
      j_idx     <= '0;
      k_idx     <= '0;
      acc       <= '0;
      step      <= '0;
      tw        <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            q_reg    <= q;
            w_reg    <= w;
            ld_idx   <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (in_fire) begin
            ld_idx <= ld_idx + 1'b1;
            if (ld_idx == LAST) begin
              in_ready <= 1'b0;
              i_idx    <= '0;
              j_idx    <= '0;
              acc      <= '0;
              tw       <= '0;
              step     <= DW'(1);
              state    <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          acc   <= acc_next;
          tw    <= tw_next;
          j_idx <= j_idx + 1'b1;
          if (j_idx == LAST) begin
            step  <= step_next;
            i_idx <= i_idx + 1'b1;
            if (i_idx == LAST) begin
              k_idx     <= '0;
              out_valid <= 1'b1;
              out_data  <= x_mem[0];
              out_last  <= 1'b0;
              state     <= OUTPUT;
            end
          end
        end
        OUTPUT: begin
          if (out_fire) begin
            if (k_idx == LAST) begin
              k_idx     <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else begin
              k_idx    <= k_nxt;
              out_data <= x_mem[k_nxt];
              out_last <= (k_nxt == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Coefficient and result buffers carry no reset; a restarted transform overwrites every entry.
  always_ff @(posedge clk) begin
    if ((state == LOAD) && in_fire) begin
      a_mem[ld_idx] <= in_data;
    end
    if ((state == COMPUTE) && (j_idx == LAST)) begin
      x_mem[i_idx] <= acc_next;
    end
  end

`ifdef NTT_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        perf_cnt <= '0;
      end
    end else if (perf_cnt != 16'hFFFF) begin
      perf_cnt <= perf_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// tb_ntt_seq_ctrl: directed checks of the sequential NTT controller against hand values and a direct DFT sum.
// Define NTT_PERF_CNT_EN to also check the busy-cycle counter.
module tb_ntt_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] q;
  logic [3:0] w;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       done;
`ifdef NTT_PERF_CNT_EN
  logic [15:0] perf_cnt;
`endif

  int n_vec;
  int n_miss;
  logic [7:0] a_vec [16];
  logic [7:0] exp_vec [16];
  int x029 [16] = '{1, 2, 4, 8, 16, 15, 13, 9, 1, 2, 4, 8, 16, 15, 13, 9};

  ntt_seq_ctrl #(.N(16), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .q         (q),
    .w         (w),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
`ifdef NTT_PERF_CNT_EN
    ,
    .perf_cnt  (perf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Direct sum of a[j]*w^(i*j) mod q, each power rebuilt from scratch.
  function automatic logic [7:0] dft_ref(input int qv, input int wv, input int i);
    int s;
    int p;
    if (qv < 2) return 8'd0;
    s = 0;
    for (int j = 0; j < 16; j++) begin
      p = 1;
      for (int e = 0; e < i * j; e++) p = (p * wv) % qv;
      s = (s + int'(a_vec[j]) * p) % qv;
    end
    return 8'(s);
  endfunction

  task automatic run_xform(input logic [7:0] qv, input logic [3:0] wv, input bit stall,
                           input bit poke_start, input int exp_perf);
    int cyc;
    int k;
    int budget;
    logic [7:0] held;
    @(negedge clk);
    q = qv; w = wv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_busy", busy, 1);
    for (int n = 0; n < 16; n++) begin
      check("load_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = a_vec[n];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 8'd0;
    check("compute_in_ready", in_ready, 0);
    if (poke_start) begin
      start = 1'b1; q = 8'd5; w = 4'd7;
    end
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    check("first_out_latency", cyc, 256);
    k = 0;
    budget = 0;
    while (k < 16 && budget < 200) begin
      out_ready = stall ? (budget % 3 == 0) : 1'b1;
      check("out_valid", out_valid, 1);
      check("out_data", out_data, exp_vec[k]);
      check("out_last", out_last, (k == 15));
      check("out_busy", busy, 1);
      held = out_data;
      @(negedge clk);
      budget++;
      if (out_ready) k++;
      else check("stall_hold", out_data, held);
    end
    check("out_count", k, 16);
    check("done_pulse", done, 1);
    check("done_idle_busy", busy, 0);
    check("done_out_valid", out_valid, 0);
`ifdef NTT_PERF_CNT_EN
    if (exp_perf >= 0) check("perf_cnt", perf_cnt, exp_perf);
`endif
    q = qv; w = wv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    check("done_single", done, 0);
    check("start_in_done_ignored", busy, 0);
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    start = 1'b0; q = 8'd0; w = 4'd0;
    in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
`ifdef NTT_PERF_CNT_EN
    check("rst_perf_cnt", perf_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] impulse at a[0], q=17 w=2");
    for (int n = 0; n < 16; n++) begin a_vec[n] = 8'd0; exp_vec[n] = 8'd1; end
    a_vec[0] = 8'd1;
    run_xform(8'd17, 4'd2, 1'b0, 1'b0, -1);

    $display("[TB] impulse at a[1], q=17 w=2");
    for (int n = 0; n < 16; n++) begin a_vec[n] = 8'd0; exp_vec[n] = 8'(x029[n]); end
    a_vec[1] = 8'd1;
    run_xform(8'd17, 4'd2, 1'b0, 1'b0, -1);

    $display("[TB] all ones, q=17 w=1");
    for (int n = 0; n < 16; n++) begin a_vec[n] = 8'd1; exp_vec[n] = 8'd16; end
    run_xform(8'd17, 4'd1, 1'b0, 1'b0, 288);

    $display("[TB] random coefficients, q=251 w=3, stalled output, start while busy");
    for (int n = 0; n < 16; n++) a_vec[n] = 8'($urandom_range(0, 255));
    for (int n = 0; n < 16; n++) exp_vec[n] = dft_ref(251, 3, n);
    run_xform(8'd251, 4'd3, 1'b1, 1'b1, -1);

    $display("[TB] reset during compute cycle 100");
    for (int n = 0; n < 16; n++) a_vec[n] = 8'($urandom_range(0, 255));
    @(negedge clk);
    q = 8'd17; w = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 16; n++) begin
      in_valid = 1'b1; in_data = a_vec[n];
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (99) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_done", done, 0);
    check("midrst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("post_reset_done", done, 0);
    for (int n = 0; n < 16; n++) begin a_vec[n] = 8'd0; exp_vec[n] = 8'(x029[n]); end
    a_vec[1] = 8'd1;
    run_xform(8'd17, 4'd2, 1'b0, 1'b0, -1);

    $display("[TB] degenerate moduli q=1 and q=0");
    for (int n = 0; n < 16; n++) begin a_vec[n] = 8'($urandom_range(0, 255)); exp_vec[n] = 8'd0; end
    run_xform(8'd1, 4'd3, 1'b0, 1'b0, -1);
    for (int n = 0; n < 16; n++) a_vec[n] = 8'($urandom_range(1, 255));
    run_xform(8'd0, 4'd5, 1'b0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
